// File: rtl/crono_pkg.sv
// crono_pkg: shared constants for the stopwatch.
//   - control state encoding (IDLE / RUN / PAUSE)
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 0-9
//   - BCD field limits and a BCD increment helper
package crono_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Field limits in BCD: centiseconds 99, seconds/minutes 59.
    localparam logic [7:0] CEN_LIMIT_BCD = 8'h99;
    localparam logic [7:0] SEC_LIMIT_BCD = 8'h59;

    // Digit value to active-low segments; 10-15 blank the digit.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return '1;
        endcase
    endfunction

    // Two-digit BCD increment that returns 00 once the limit is reached,
    // so no out-of-range intermediate value is ever stored.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        if (v == limit)
            return '0;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit to active-low 7-segment decode.
//   bcd : input  [3:0] digit value (10-15 decode to all segments off)
//   seg : output [6:0] active-low segments {g,f,e,d,c,b,a}
module bcd_to_7seg
    import crono_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pattern(bcd);
    end

endmodule

// File: rtl/crono_counter.sv
// crono_counter: mm:ss.cc stopwatch with a multiplexed 4-digit display.
//   clk       : system clock, all state on rising edge
//   reset     : synchronous active-low reset
//   tick_cen  : one-cycle 100 Hz centisecond tick
//   btn_ss    : start/stop level (debounced), acts on rising edge
//   btn_clr   : clear level (debounced), acts on rising edge
//   disp_mode : 0 shows ss.cc, 1 shows mm.ss
//   cen_bcd, sec_bcd, min_bcd : time fields as two BCD digits
//   running   : high while in RUN
//   wrap      : one-cycle pulse on 59:59.99 -> 00:00.00
//   Num       : active-low segments {dp,g,f,e,d,c,b,a} of the enabled digit
//   an        : active-low digit enable, an[0] rightmost
module crono_counter
    import crono_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_cen,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       disp_mode,
    output logic [7:0] cen_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       wrap,
    output logic [7:0] Num,
    output logic [3:0] an
);

    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic          ss_prev, clr_prev;
    logic          ss_edge, clr_edge;
    logic [7:0]    cen_q, sec_q, min_q;
    logic          wrap_q;
    logic          count_en, clear_fields;
    logic          carry_c, carry_s, carry_m;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_sel;
    logic [3:0]    nibble;
    logic [6:0]    seg;
    logic [7:0]    num_q;
    logic [3:0]    an_q;

    always_comb begin
        ss_edge      = btn_ss & ~ss_prev;
        clr_edge     = btn_clr & ~clr_prev;
        // Counting looks at the registered state, so a tick on the
        // RUN->PAUSE edge counts and one on the ->RUN edge does not.
        count_en     = (state_q == ST_RUN) && tick_cen;
        clear_fields = (state_q == ST_PAUSE) && clr_edge;
        carry_c      = (cen_q == CEN_LIMIT_BCD);
        carry_s      = carry_c && (sec_q == SEC_LIMIT_BCD);
        carry_m      = carry_s && (min_q == SEC_LIMIT_BCD);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ss_edge) state_d = ST_RUN;
            ST_RUN:   if (ss_edge) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (clr_edge)     state_d = ST_IDLE;
                else if (ss_edge) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            // Load the current button levels so a button held across
            // reset release does not look like a fresh press.
            ss_prev  <= btn_ss;
            clr_prev <= btn_clr;
            cen_q    <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ss_prev  <= btn_ss;
            clr_prev <= btn_clr;
            wrap_q   <= count_en && carry_m;
            if (clear_fields) begin
                cen_q <= '0;
                sec_q <= '0;
                min_q <= '0;
            end else if (count_en) begin
                cen_q <= bcd_inc(cen_q, CEN_LIMIT_BCD);
                if (carry_c) sec_q <= bcd_inc(sec_q, SEC_LIMIT_BCD);
                if (carry_s) min_q <= bcd_inc(min_q, SEC_LIMIT_BCD);
            end
        end
    end

    // Display multiplexing: digit_sel walks 0..3 right to left.
    always_comb begin
        nibble = '0;
        case (digit_sel)
            2'd0: nibble = disp_mode ? sec_q[3:0] : cen_q[3:0];
            2'd1: nibble = disp_mode ? sec_q[7:4] : cen_q[7:4];
            2'd2: nibble = disp_mode ? min_q[3:0] : sec_q[3:0];
            2'd3: nibble = disp_mode ? min_q[7:4] : sec_q[7:4];
            default: nibble = '0;
        endcase
    end

    bcd_to_7seg u_seg (
        .bcd (nibble),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_sel <= '0;
            an_q      <= 4'b1110;
            num_q     <= {1'b1, SEG_0};
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                scan_cnt  <= scan_cnt + SW'(1);
            end
            an_q  <= ~(4'b0001 << digit_sel);
            num_q <= {(digit_sel != 2'd2), seg};
        end
    end

    assign cen_bcd = cen_q;
    assign sec_bcd = sec_q;
    assign min_bcd = min_q;
    assign running = (state_q == ST_RUN);
    assign wrap    = wrap_q;
    assign Num     = num_q;
    assign an      = an_q;

endmodule

// File: doc/crono_counter.md
CRONO_COUNTER -- requirements
Module: crono_counter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 25_000, meaning clk cycles each display digit stays enabled (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port tick_cen, input, 1, one-cycle 100 Hz pulse from the centisecond clock divider.
REQ-005 The block SHALL have port btn_ss, input, 1, start/stop level (externally debounced).
REQ-006 The block SHALL have port btn_clr, input, 1, clear level (externally debounced).
REQ-007 The block SHALL have port disp_mode, input, 1, display select: 0 shows ss.cc, 1 shows mm.ss.
REQ-008 The block SHALL have port cen_bcd, output, 8, centiseconds as two BCD digits, range 00-99.
REQ-009 The block SHALL have port sec_bcd, output, 8, seconds as two BCD digits, range 00-59.
REQ-010 The block SHALL have port min_bcd, output, 8, minutes as two BCD digits, range 00-59.
REQ-011 The block SHALL have port running, output, 1, high while in state RUN.
REQ-012 The block SHALL have port wrap, output, 1, one-cycle pulse on rollover from 59:59.99 to 00:00.00.
REQ-013 The block SHALL have port Num, output, 8, active-low segments {dp,g,f,e,d,c,b,a} of the enabled digit.
REQ-014 The block SHALL have port an, output, 4, active-low digit enable; an[0] is the rightmost digit.

Function
REQ-015 btn_ss and btn_clr SHALL be rising-edge detected using a registered previous value; only the edge acts, and a held level SHALL not repeat the action.
REQ-016 The control FSM SHALL have states IDLE, RUN and PAUSE.
REQ-017 FSM transitions SHALL be: IDLE -ss-> RUN; RUN -ss-> PAUSE; PAUSE -ss-> RUN; PAUSE -clr-> IDLE; clr in IDLE or RUN ignored.
REQ-018 Simultaneous ss and clr edges SHALL give: PAUSE -> IDLE (clr wins); IDLE -> RUN; RUN -> PAUSE.
REQ-019 Entering IDLE SHALL zero cen_bcd, sec_bcd and min_bcd in the same edge.
REQ-020 Counting SHALL use the registered state: a tick_cen coinciding with the RUN->PAUSE edge is counted; a tick coinciding with IDLE/PAUSE->RUN is not.
REQ-021 Each counted tick SHALL increment the time by 0.01 s, with BCD outputs updated on the clock edge that samples the tick (outputs valid next cycle).
REQ-022 Carries: cc 99->00 increments ss; ss 59->00 increments mm; mm 59->00 wraps all fields to zero and asserts wrap for exactly one cycle.
REQ-023 Each BCD nibble SHALL stay in 0-9 and each tens nibble within its field's range; no binary intermediate exceeding the field range SHALL be exposed.
REQ-024 A scan counter SHALL advance the enabled digit every SCAN_DIV cycles in the order an = 1110, 1101, 1011, 0111, then wrap, independent of the FSM state.
REQ-025 With disp_mode=0 the digits SHALL be, from an[3] to an[0], sec tens, sec units, cen tens, cen units; with disp_mode=1 they SHALL be min tens, min units, sec tens, sec units.
REQ-026 The decimal point SHALL be lit (Num[7]=0) only while an[2] is enabled.
REQ-027 Num and an SHALL be registered and SHALL change on the same edge.
REQ-028 A disp_mode change SHALL take effect at the next Num/an register update.

Reset
REQ-029 While reset=0 at a clock edge, the block SHALL enter IDLE and clear all BCD fields, edge-detect registers, the scan counter and wrap.
REQ-030 After that edge, running=0, an=1110 and Num SHALL show digit 0 with dp off (8'b11000000).
REQ-031 Reset mid-count SHALL discard the time; a button held high across reset release SHALL not generate an edge.

Structure
REQ-032 The package crono_pkg SHALL hold the state encoding IDLE/RUN/PAUSE, the 7-segment patterns for digits 0-9 and the field limits (99, 59).
REQ-033 A sub-module bcd_to_7seg SHALL provide the combinational 4-bit BCD to active-low 7-segment decode; values 10-15 SHALL decode to all segments off.

Verification
REQ-034 Reset, then btn_ss pulse, then 150 ticks SHALL give sec_bcd=8'h01, cen_bcd=8'h50, running=1.
REQ-035 Preload 59:59.98 in RUN, then 2 ticks SHALL give 00:00.00 with wrap high exactly one cycle after the second tick.
REQ-036 RUN, btn_ss edge coincident with a tick SHALL count that tick; then PAUSE plus 10 ticks SHALL leave the count unchanged; then btn_clr SHALL give IDLE with all fields 00.
REQ-037 Simultaneous ss and clr edges in PAUSE SHALL give IDLE; in RUN they SHALL give PAUSE with the count kept.
REQ-038 With SCAN_DIV=4 and time 12.34 at disp_mode=0, an SHALL cycle 1110/1101/1011/0111 every 4 cycles with Num = 4, 3, 2 with dp, 1.
REQ-039 Assert reset while in RUN at 07.00 and hold btn_ss high across release: the result SHALL be IDLE, all fields 00, and no start until btn_ss falls and rises again.
